pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath/address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h00000000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  hold PC and all state this cycle.
REQ-006 SHALL have port halt  input  1  enter HALT state (sticky until reset).
REQ-007 SHALL have port branch  input  1  resolved taken branch (branch AND zero).
REQ-008 SHALL have port branch_imm  input  WIDTH  sign-extended immediate, word offset, not yet shifted.
REQ-009 SHALL have port jump  input  1  J-type redirect.
REQ-010 SHALL have port jump_index  input  26  J-type instr_index field.
REQ-011 SHALL have port jr  input  1  register-indirect redirect.
REQ-012 SHALL have port jr_target  input  WIDTH  register value for jr.
REQ-013 SHALL have port pc  output  WIDTH  current fetch address.
REQ-014 SHALL have port pc_plus4  output  WIDTH  pc + 4, combinational from pc.
REQ-015 SHALL have port valid  output  1  pc holds a fetchable instruction this cycle.
REQ-016 SHALL have port halted  output  1  high while in HALT.
REQ-017 SHALL have port misaligned  output  1  one-cycle pulse: accepted jr had jr_target[1:0] != 0.

Function
REQ-018 SHALL implement states BOOT, RUN, HALT; BOOT -> RUN unconditionally on first edge after reset release; RUN -> HALT when halt=1; HALT exits only via rst_n.
REQ-019 In BOOT SHALL drive pc=RESET_VECTOR, valid=0; in RUN valid=1 unless stall=1; in HALT valid=0, pc frozen.
REQ-020 In RUN, next-pc priority SHALL be halt > stall > jr > jump > branch > sequential (pc_plus4).
REQ-021 Branch target SHALL be pc_plus4 + (branch_imm << 2), modulo 2^WIDTH, bits shifted out of the top discarded.
REQ-022 Jump target SHALL be {pc_plus4[31:28], jump_index, 2'b00}.
REQ-023 Jr target SHALL be {jr_target[WIDTH-1:2], 2'b00}; misaligned SHALL pulse on the same edge pc loads it when jr_target[1:0] != 0.
REQ-024 pc_plus4 SHALL wrap: pc=32'hFFFFFFFC gives pc_plus4=32'h00000000.
REQ-025 stall=1 SHALL hold pc, state and pending redirect unchanged; redirect inputs ignored that cycle.
REQ-026 halt=1 coincident with a redirect SHALL enter HALT with pc unchanged; redirect discarded.
REQ-027 Redirect inputs SHALL be ignored in BOOT and HALT.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk, force state=BOOT, pc=RESET_VECTOR, valid=0, halted=0, misaligned=0, pending redirect cleared.
REQ-029 Reset asserted mid-redirect or mid-stall SHALL discard all in-flight state; first RUN fetch after release is RESET_VECTOR.

Configuration
REQ-030 Macro BRANCH_DELAY_SLOT_EN SHALL select redirect timing.
REQ-031 Without BRANCH_DELAY_SLOT_EN: accepted redirect SHALL load target into pc on the next edge (no delay slot).
REQ-032 With BRANCH_DELAY_SLOT_EN: accepted redirect SHALL be captured into a pending register, pc SHALL advance to pc_plus4 (delay slot) on the next edge, then to the target on the following non-stalled edge.
REQ-033 With BRANCH_DELAY_SLOT_EN: a redirect asserted while one is pending SHALL be ignored; misaligned SHALL pulse when the jr is accepted, not when applied.

Verification
REQ-034 Reset release, no inputs, 4 edges -> pc sequence 0x0 (valid=0), 0x0, 0x4, 0x8, 0xC (valid=1).
REQ-035 pc=0x100, branch=1, branch_imm=32'hFFFFFFFE -> next pc 0xFC; branch_imm=32'h00000003 from 0x100 -> 0x110.
REQ-036 pc=0x40000010, jump=1, jump_index=26'h0000040 -> next pc 0x40000100; same cycle branch=1 -> jump wins.
REQ-037 jr=1, jr_target=32'h00400003 -> next pc 0x00400000, misaligned=1 for exactly one cycle.
REQ-038 stall=1 for 3 cycles with branch=1 -> pc unchanged throughout; halt=1 then -> halted=1, valid=0, pc frozen until rst_n low, async return to 0x0.
REQ-039 With BRANCH_DELAY_SLOT_EN, pc=0x20, branch=1, branch_imm=4 -> pc 0x24 then 0x34; second branch during pending ignored.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a BOOT/RUN/HALT FSM, branch/jump/jr redirects and stall/halt control.
// Define BRANCH_DELAY_SLOT_EN to give redirects one architectural delay slot before the target is fetched.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch,
  input  logic [WIDTH-1:0] branch_imm,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             valid,
  output logic             halted,
  output logic             misaligned
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic             misaligned_reg, misaligned_next;
  logic [WIDTH-1:0] pc_plus4_w;
  logic [WIDTH-1:0] branch_target, jump_target, jr_aligned, redirect_target;
  logic             jr_unaligned;

  assign pc_plus4_w    = pc_reg + WIDTH'(4);
  assign branch_target = pc_plus4_w + (branch_imm << 2);
  assign jump_target   = {pc_plus4_w[WIDTH-1:28], jump_index, 2'b00};
  assign jr_aligned    = {jr_target[WIDTH-1:2], 2'b00};
  assign jr_unaligned  = jr && (jr_target[1:0] != 2'b00);

  // Redirect priority jr > jump > branch; falls through to sequential fetch.
  always_comb begin
    redirect_target = pc_plus4_w;
    if (jr) begin
      redirect_target = jr_aligned;
    end else if (jump) begin
      redirect_target = jump_target;
    end else if (branch) begin
      redirect_target = branch_target;
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  logic             pend_valid_reg, pend_valid_next;
  logic [WIDTH-1:0] pend_target_reg, pend_target_next;
  logic             redirect_req;

  assign redirect_req = jr || jump || branch;
`endif

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_VECTOR;
      misaligned_reg  <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      misaligned_reg  <= misaligned_next;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
`endif
    end
  end

  // Next-state and next-pc logic
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    misaligned_next = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
`endif
    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (halt) begin
          state_next = HALT;
        end else if (!stall) begin
`ifdef BRANCH_DELAY_SLOT_EN
          if (pend_valid_reg) begin
            // Delay slot already fetched: apply the captured target, ignore new redirects.
            pc_next         = pend_target_reg;
            pend_valid_next = 1'b0;
          end else begin
            pc_next = pc_plus4_w;
            if (redirect_req) begin
              pend_valid_next  = 1'b1;
              pend_target_next = redirect_target;
              misaligned_next  = jr_unaligned;
            end
          end
`else
          pc_next         = redirect_target;
          misaligned_next = jr_unaligned;
`endif
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // Outputs
  always_comb begin
    pc         = pc_reg;
    pc_plus4   = pc_plus4_w;
    valid      = (state_reg == RUN) && !stall;
    halted     = (state_reg == HALT);
    misaligned = misaligned_reg;
  end

endmodule
